// File: rtl/seq_alu_if.sv
// Operand/opcode request channel and result/flag response channel of seq_alu.
// The master drives operands and consumes results; the slave is the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             carry;
  logic             sign;
  logic             ov;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, z, carry, sign, ov, zero, err
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, z, carry, sign, ov, zero, err
  );
endinterface

// File: rtl/seq_alu.sv
// Registered, handshaked ALU with an iterative shift-add unsigned multiplier.
// Defining SEQ_ALU_STICKY_OV_EN adds the ov_clr input and ov_sticky output.
module seq_alu #(
  parameter int WIDTH = 12
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SEQ_ALU_STICKY_OV_EN
  input  logic ov_clr,
  output logic ov_sticky,
`endif
  seq_alu_if.slave bus
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   z_q;
  logic               carry_q;
  logic               ov_q;
  logic               zero_q;
  logic               err_q;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      count_q, count_d;

  logic [WIDTH:0]     sumW;
  logic [WIDTH:0]     diffW;
  logic [WIDTH-1:0]   negA;
  logic [WIDTH-1:0]   aluZ;
  logic               aluCarry;
  logic               aluOv;
  logic               aluErr;

  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] prodStep;

  logic               loadRes;
  logic [WIDTH-1:0]   resZ;
  logic               resCarry;
  logic               resOv;
  logic               resErr;

  assign sumW  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diffW = {1'b0, bus.a} - {1'b0, bus.b};
  assign negA  = '0 - bus.a;

  always_comb begin
    aluZ     = '0;
    aluCarry = 1'b0;
    aluOv    = 1'b0;
    aluErr   = 1'b0;
    case (bus.op)
      4'd0: begin
        aluZ  = bus.a[MSB] ? negA : bus.a;
        // Only the most negative value stays negative after negation
        aluOv = bus.a[MSB] & negA[MSB];
      end
      4'd1: begin
        aluZ     = {bus.b[WIDTH-2:0], 1'b0};
        aluCarry = bus.b[MSB];
        aluOv    = bus.b[MSB] ^ bus.b[MSB-1];
      end
      4'd2: aluZ = bus.a & bus.b;
      4'd3: aluZ = bus.a | bus.b;
      4'd4: aluZ = bus.a ^ bus.b;
      4'd5: aluZ = ~bus.a;
      4'd6: begin
        aluZ     = sumW[WIDTH-1:0];
        aluCarry = sumW[WIDTH];
        aluOv    = (bus.a[MSB] == bus.b[MSB]) && (sumW[MSB] != bus.a[MSB]);
      end
      4'd7: begin
        aluZ     = diffW[WIDTH-1:0];
        aluCarry = diffW[WIDTH];
        aluOv    = (bus.a[MSB] != bus.b[MSB]) && (diffW[MSB] != bus.a[MSB]);
      end
      4'd8: aluZ = '0;
      default: aluErr = 1'b1;
    endcase
  end

  // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits
  assign partial  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign prodStep = {partial, prod_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    count_d  = count_q;
    loadRes  = 1'b0;
    resZ     = aluZ;
    resCarry = aluCarry;
    resOv    = aluOv;
    resErr   = aluErr;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.op == 4'd8) begin
            mcand_d = bus.a;
            prod_d  = {{WIDTH{1'b0}}, bus.b};
            count_d = CW'(WIDTH);
            state_d = EXEC;
          end else begin
            loadRes = 1'b1;
            state_d = DONE;
          end
        end
      end
      EXEC: begin
        prod_d  = prodStep;
        count_d = count_q - CW'(1);
        // The final iteration and the result register share one edge
        if (count_q == CW'(1)) begin
          loadRes  = 1'b1;
          resZ     = prodStep[WIDTH-1:0];
          resCarry = |prodStep[2*WIDTH-1:WIDTH];
          resOv    = |prodStep[2*WIDTH-1:WIDTH];
          resErr   = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      z_q     <= '0;
      carry_q <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      mcand_q <= '0;
      prod_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      count_q <= count_d;
      if (loadRes) begin
        z_q     <= resZ;
        carry_q <= resCarry;
        ov_q    <= resOv;
        zero_q  <= (resZ == '0);
        err_q   <= resErr;
      end
    end
  end

`ifdef SEQ_ALU_STICKY_OV_EN
  logic ovSticky_q;

  // A new overflow takes priority over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovSticky_q <= 1'b0;
    end else if (loadRes && resOv) begin
      ovSticky_q <= 1'b1;
    end else if (ov_clr) begin
      ovSticky_q <= 1'b0;
    end
  end

  assign ov_sticky = ovSticky_q;
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.z         = z_q;
  assign bus.carry     = carry_q;
  assign bus.sign      = z_q[MSB];
  assign bus.ov        = ov_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=12): directed plan plus random ops
// checked against an arithmetic reference model. Honors SEQ_ALU_STICKY_OV_EN.
module tb_seq_alu;

  localparam int W = 12;

  typedef struct packed {
    logic [W-1:0] z;
    logic         carry;
    logic         ov;
    logic         zero;
    logic         err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

`ifdef SEQ_ALU_STICKY_OV_EN
  logic ovClr;
  logic ovSticky;
  logic clrAtAccept;
  logic stickyExp;
`endif

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SEQ_ALU_STICKY_OV_EN
    .ov_clr    (ovClr),
    .ov_sticky (ovSticky),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on unsigned and signed views
  function automatic exp_t refModel(input int op, input int a, input int b);
    exp_t   e;
    int     sa;
    int     sb;
    int     v;
    longint p;
    e  = '0;
    v  = 0;
    sa = (a >= 2048) ? a - 4096 : a;
    sb = (b >= 2048) ? b - 4096 : b;
    case (op)
      0: begin v = (sa < 0) ? -sa : sa; e.ov = (v > 2047); end
      1: begin
        v       = b * 2;
        e.carry = (b >= 2048);
        e.ov    = (sb * 2 > 2047) || (sb * 2 < -2048);
      end
      2: v = a & b;
      3: v = a | b;
      4: v = a ^ b;
      5: v = ~a;
      6: begin
        v       = a + b;
        e.carry = (v > 4095);
        e.ov    = (sa + sb > 2047) || (sa + sb < -2048);
      end
      7: begin
        v       = a - b;
        e.carry = (a < b);
        e.ov    = (sa - sb > 2047) || (sa - sb < -2048);
      end
      8: begin
        p       = longint'(a) * longint'(b);
        v       = int'(p % 4096);
        e.carry = (p > 4095);
        e.ov    = (p > 4095);
      end
      default: begin v = 0; e.err = 1'b1; end
    endcase
    e.z    = v[W-1:0];
    e.zero = (e.z == '0);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int hold);
    exp_t e;
    int   lat;
    e = refModel(int'(op), int'(a), int'(b));
    @(negedge clk);
    checkOutput("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
`ifdef SEQ_ALU_STICKY_OV_EN
    ovClr = clrAtAccept;
`endif
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.op       = 4'($urandom);
`ifdef SEQ_ALU_STICKY_OV_EN
    ovClr = 1'b0;
    if (clrAtAccept) stickyExp = 1'b0;
    if (e.ov) stickyExp = 1'b1;
`endif
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      if (lat == 5) checkOutput("in_ready_exec", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), (op == 4'd8) ? 32'd13 : 32'd1);
    checkOutput("z",     32'(bus.z),     32'(e.z));
    checkOutput("carry", 32'(bus.carry), 32'(e.carry));
    checkOutput("sign",  32'(bus.sign),  32'(e.z[W-1]));
    checkOutput("ov",    32'(bus.ov),    32'(e.ov));
    checkOutput("zero",  32'(bus.zero),  32'(e.zero));
    checkOutput("err",   32'(bus.err),   32'(e.err));
`ifdef SEQ_ALU_STICKY_OV_EN
    checkOutput("ov_sticky", 32'(ovSticky), 32'(stickyExp));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      bus.op       = 4'($urandom);
      checkOutput("hold_in_ready",  32'(bus.in_ready),  32'd0);
      checkOutput("hold_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("hold_z",         32'(bus.z),         32'(e.z));
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("drain_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("drain_in_ready",  32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
`ifdef SEQ_ALU_STICKY_OV_EN
    ovClr       = 1'b0;
    clrAtAccept = 1'b0;
    stickyExp   = 1'b0;
`endif
    #12;
    checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_z",         32'(bus.z),         32'd0);
    checkOutput("rst_zero",      32'(bus.zero),      32'd0);
    checkOutput("rst_err",       32'(bus.err),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed plan");
    applyStimulus(4'd6, 12'h7FF, 12'h001, 0);
    applyStimulus(4'd7, 12'h000, 12'h001, 0);
    applyStimulus(4'd0, 12'h800, 12'h000, 0);
    applyStimulus(4'd8, 12'h040, 12'h040, 0);
    applyStimulus(4'd8, 12'h00F, 12'h011, 0);
    applyStimulus(4'd6, 12'h123, 12'h456, 5);
    applyStimulus(4'd12, 12'h5A5, 12'h0F0, 0);
    applyStimulus(4'd1, 12'h000, 12'h600, 1);

`ifdef SEQ_ALU_STICKY_OV_EN
    applyStimulus(4'd6, 12'h7FF, 12'h001, 0);
    applyStimulus(4'd2, 12'h0F0, 12'h0FF, 0);
    clrAtAccept = 1'b1;
    applyStimulus(4'd6, 12'h7FF, 12'h001, 0);
    applyStimulus(4'd2, 12'h0F0, 12'h0FF, 0);
    clrAtAccept = 1'b0;
`endif

    // Reset pulse in the middle of a multiply discards it
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 4'd8;
    bus.a        = 12'h0AB;
    bus.b        = 12'h0CD;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    checkOutput("midrst_z",         32'(bus.z),         32'd0);
    checkOutput("midrst_flags",
                32'({bus.carry, bus.sign, bus.ov, bus.zero, bus.err}), 32'd0);
`ifdef SEQ_ALU_STICKY_OV_EN
    stickyExp = 1'b0;
    checkOutput("midrst_sticky", 32'(ovSticky), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("postrst_out_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] random ops");
    for (int n = 0; n < 30; n++) begin
      applyStimulus(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
                    int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
